// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with HMASTLOCK support and registered one-hot grant.
// Optional hold-time limit for unlocked owners is enabled by defining AHB_ARB_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_IDLE   | no owner, sel = 0
//   ST_GRANT  | owner holds the bus, unlocked transfer
//   ST_LOCKED | owner holds the bus with HMASTLOCK asserted
module ahb_arbiter #(
    parameter int CHANNEL_NUM = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [CHANNEL_NUM-1:0]         req,
    input  logic [CHANNEL_NUM-1:0]         lock,
    input  logic                           hready,
    output logic [CHANNEL_NUM-1:0]         sel,
    output logic                           grant_valid,
    output logic [$clog2(CHANNEL_NUM)-1:0] master_id
);

    localparam int ID_W = $clog2(CHANNEL_NUM);
    localparam logic [ID_W:0] CH_EXT = (ID_W+1)'(CHANNEL_NUM);

    if (CHANNEL_NUM < 2 || CHANNEL_NUM > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("ahb_arbiter: CHANNEL_NUM must be 2..16 and MAX_HOLD >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CHANNEL_NUM-1:0] sel_q;
    logic                   grant_valid_q;
    logic [ID_W-1:0]        master_id_q;
    logic [ID_W-1:0]        ptr_q;

    logic [CHANNEL_NUM-1:0] cand;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   win_found;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W:0]          scan_idx;
    logic [ID_W-1:0]        ptr_d;
    logic                   timeout;
    logic                   do_grant;
    logic                   go_idle;

    // The current owner is masked out so a released owner waits its full turn.
    assign cand       = req & ~sel_q;
    assign owner_req  = |(req & sel_q);
    assign owner_lock = |(lock & sel_q);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (scan_idx >= CH_EXT) begin
                scan_idx = scan_idx - CH_EXT;
            end
            if (!win_found && cand[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    assign ptr_d = (win_idx == ID_W'(CHANNEL_NUM - 1)) ? '0 : win_idx + ID_W'(1);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic             others_pend;

    assign others_pend = |cand;
    // A lock request on the timeout edge wins: locked sequences are never broken.
    assign timeout = (state_q == ST_GRANT) && (hold_cnt_q == CNT_MAX)
                     && others_pend && !owner_lock;
`else
    assign timeout = 1'b0;
`endif

    assign do_grant = win_found && ((state_q == ST_IDLE) || !owner_req || timeout);
    assign go_idle  = !win_found && (state_q != ST_IDLE) && !owner_req;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            grant_valid_q <= 1'b0;
            master_id_q   <= '0;
            ptr_q         <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
`endif
        end else if (hready) begin
            if (do_grant) begin
                state_q       <= lock[win_idx] ? ST_LOCKED : ST_GRANT;
                sel_q         <= CHANNEL_NUM'(1) << win_idx;
                grant_valid_q <= 1'b1;
                master_id_q   <= win_idx;
                ptr_q         <= ptr_d;
`ifdef AHB_ARB_TIMEOUT_EN
                hold_cnt_q    <= '0;
`endif
            end else if (go_idle) begin
                state_q       <= ST_IDLE;
                sel_q         <= '0;
                grant_valid_q <= 1'b0;
                master_id_q   <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
                hold_cnt_q    <= '0;
`endif
            end else if (state_q == ST_GRANT && owner_lock) begin
                state_q <= ST_LOCKED;
`ifdef AHB_ARB_TIMEOUT_EN
                hold_cnt_q <= '0;
`endif
            end else if (state_q == ST_LOCKED && !owner_lock) begin
                state_q <= ST_GRANT;
`ifdef AHB_ARB_TIMEOUT_EN
                hold_cnt_q <= '0;
`endif
            end
`ifdef AHB_ARB_TIMEOUT_EN
            else if (state_q == ST_GRANT && hold_cnt_q != CNT_MAX) begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end
`endif
        end
    end

    assign sel         = sel_q;
    assign grant_valid = grant_valid_q;
    assign master_id   = master_id_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (4 channels, MAX_HOLD 16); expectations follow AHB_ARB_TIMEOUT_EN.
module tb_ahb_arbiter;

`ifdef AHB_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req;
    logic [3:0] lock;
    logic       hready;
    logic [3:0] sel;
    logic       grant_valid;
    logic [1:0] master_id;

    int checks = 0;
    int errors = 0;

    ahb_arbiter #(.CHANNEL_NUM(4), .MAX_HOLD(16)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req         (req),
        .lock        (lock),
        .hready      (hready),
        .sel         (sel),
        .grant_valid (grant_valid),
        .master_id   (master_id)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] exp_sel);
        logic [1:0] exp_id;
        exp_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (exp_sel[i]) exp_id = 2'(i);
        end
        check({tag, "/sel"}, 32'(sel), 32'(exp_sel));
        check({tag, "/gv"},  32'(grant_valid), 32'(|exp_sel));
        check({tag, "/id"},  32'(master_id), 32'(exp_id));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        hready  = 1'b1;
        cyc(2);
        chk_grant("reset", 4'b0000);

        HRESETn = 1'b1;
        cyc(1);
        chk_grant("first_grant", 4'b0001);

        req = 4'b1110;
        cyc(1);
        chk_grant("rr_next", 4'b0010);

        req = 4'b0100;
        cyc(1);
        chk_grant("rr_to2", 4'b0100);

        req = 4'b0011;
        cyc(1);
        chk_grant("wrap", 4'b0001);

        req = 4'b0010;
        cyc(1);
        chk_grant("rel0", 4'b0010);

        req = 4'b0011;
        cyc(1);
        chk_grant("hold1", 4'b0010);

        req = 4'b0101;
        cyc(1);
        chk_grant("rr_turn", 4'b0100);

        hready = 1'b0;
        req    = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk_grant("hready_stall", 4'b0100);
        end
        hready = 1'b1;
        cyc(1);
        chk_grant("after_stall", 4'b1000);

        req = 4'b0000;
        cyc(1);
        chk_grant("to_idle", 4'b0000);
        cyc(1);
        chk_grant("stay_idle", 4'b0000);

        req = 4'b0110;
        cyc(1);
        chk_grant("idle_grant", 4'b0010);

        req  = 4'b1111;
        lock = 4'b0010;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            chk_grant("locked_hold", 4'b0010);
        end
        lock = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            cyc(1);
            chk_grant("unlock_hold", 4'b0010);
        end
        cyc(1);
        chk_grant("unlock_timeout", TMO ? 4'b0100 : 4'b0010);

        req = 4'b0000;
        cyc(1);
        chk_grant("idle2", 4'b0000);
        req = 4'b0001;
        cyc(1);
        chk_grant("grant0", 4'b0001);
        req = 4'b0011;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            chk_grant("alternate", (TMO && ((k / 16) % 2 == 1)) ? 4'b0010 : 4'b0001);
        end

        req  = 4'b1000;
        lock = 4'b1000;
        cyc(1);
        chk_grant("lock3", 4'b1000);
        cyc(2);
        chk_grant("lock3_hold", 4'b1000);
        HRESETn = 1'b0;
        hready  = 1'b0;
        cyc(1);
        chk_grant("reset_locked", 4'b0000);

        HRESETn = 1'b1;
        hready  = 1'b1;
        lock    = 4'b0000;
        req     = 4'b1111;
        cyc(1);
        chk_grant("post_reset", 4'b0001);
        req = 4'b1110;
        cyc(1);
        chk_grant("post_reset_rr", 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
